// File: rtl/rr_crossbar_router_pkg.sv
// Shared constants and types for the router core: port directions and default item geometry.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package rr_crossbar_router_pkg;

  // Port indices of a 5-port mesh node; LOCAL is always the last port.
  localparam int DIRECTIONS   = 5;
  localparam int DEF_ITEM_W   = 32;
  localparam int DEF_DIR_W    = 3;
  localparam int DEF_TAIL_BIT = 31;
  localparam int DEF_DROP_W   = 8;

  typedef enum logic [DEF_DIR_W-1:0] {
    NORTH = 3'd0,
    EAST  = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } dir_e;

  // Item layout for the default geometry: tail flag on the top bit.
  typedef struct packed {
    logic                  tail;
    logic [DEF_ITEM_W-2:0] body;
  } item_t;

  // Number of set bits in a vector of up to 32 bits.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int b = 0; b < 32; b++) begin
      n = n + {5'd0, v[b]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_crossbar_router_if.sv
// Bundles the input-FIFO side (valid/read) and output-link side (ena/busy) of the router.
// Latency: n/a (wiring only).
// Backpressure: in_read pops the input FIFOs; out_busy stalls the matching output.
interface rr_crossbar_router_if
  import rr_crossbar_router_pkg::*;
#(
  parameter int NPORTS = DIRECTIONS,
  parameter int ITEM_W = DEF_ITEM_W,
  parameter int DIR_W  = DEF_DIR_W
) ();

  logic [NPORTS*ITEM_W-1:0] in_data;
  logic [NPORTS*DIR_W-1:0]  in_dir;
  logic [NPORTS-1:0]        in_valid;
  logic [NPORTS-1:0]        in_read;
  logic [NPORTS*ITEM_W-1:0] out_data;
  logic [NPORTS-1:0]        out_ena;
  logic [NPORTS-1:0]        out_busy;

  // Upstream FIFOs plus downstream links, i.e. whatever surrounds the router.
  modport master (
    output in_data, in_dir, in_valid, out_busy,
    input  in_read, out_data, out_ena
  );

  // The router core itself.
  modport slave (
    input  in_data, in_dir, in_valid, out_busy,
    output in_read, out_data, out_ena
  );

endinterface

// File: rtl/rr_crossbar_router_arbiter_n.sv
// Round-robin arbiter: N requests -> one-hot grant, search starts one past the last winner.
// Latency: grant is combinational from req; pointer updates on the following edge.
// Backpressure: hold freezes the pointer (used while an output is wormhole-locked).
module rr_arbiter_n
  import rr_crossbar_router_pkg::*;
#(
  parameter int N = DIRECTIONS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         hold,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx;
  logic          win;

  // Walk the requests starting at ptr+1 and wrapping; first requester wins.
  always_comb begin
    gnt     = '0;
    win     = 1'b0;
    win_idx = ptr;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!win && req[idx]) begin
        win      = 1'b1;
        win_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  // Remember the last winner so it has lowest priority next time; frozen under hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PW'(N - 1);
    end else if (win && !hold) begin
      ptr <= win_idx;
    end
  end

endmodule

// File: rtl/rr_crossbar_router.sv
// N-port router core: per-output round-robin arbitration, one-hot crossbar, registered outputs, drop counter.
// Latency: grant in cycle t -> out_data/out_ena in cycle t+1; in_read is combinational in cycle t.
// Backpressure: out_busy[o] blocks all grants to o in the same cycle; busy must be raised almost-full.
module rr_crossbar_router
  import rr_crossbar_router_pkg::*;
#(
  parameter int NPORTS   = DIRECTIONS,
  parameter int ITEM_W   = DEF_ITEM_W,
  parameter int DIR_W    = DEF_DIR_W,
  parameter int LOCK_EN  = 1,
  parameter int TAIL_BIT = DEF_TAIL_BIT,
  parameter int DROP_W   = DEF_DROP_W
) (
  input  logic                clk,
  input  logic                reset,
  rr_crossbar_router_if.slave bus,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  // Wide enough to hold a saturated count plus one cycle's worth of drops.
  localparam int CW = DROP_W + $clog2(NPORTS + 1);

  logic [ITEM_W-1:0] item     [NPORTS];
  logic [DIR_W-1:0]  dir      [NPORTS];
  logic [NPORTS-1:0] req      [NPORTS];   // req[o][i]: input i wants output o
  logic [NPORTS-1:0] gnt      [NPORTS];   // gnt[o][i]: one-hot winner per output
  logic [PW-1:0]     gnt_idx  [NPORTS];
  logic [ITEM_W-1:0] xbar     [NPORTS];
  logic [ITEM_W-1:0] out_q    [NPORTS];
  logic [PW-1:0]     lock_src [NPORTS];
  logic [NPORTS-1:0] lock_v;
  logic [NPORTS-1:0] gnt_any;
  logic [NPORTS-1:0] drop;
  logic [NPORTS-1:0] rd;
  logic [NPORTS-1:0] ena_q;
  logic [CW-1:0]     drop_sum;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign item[p] = bus.in_data[p*ITEM_W +: ITEM_W];
    assign dir[p]  = bus.in_dir[p*DIR_W +: DIR_W];
    assign bus.out_data[p*ITEM_W +: ITEM_W] = out_q[p];
  end
  assign bus.out_ena = ena_q;

  // Unroutable items (U-turn or direction past the last port) are popped and discarded.
  // Nothing is popped while reset is held, so no item is lost across a reset.
  always_comb begin
    drop = '0;
    for (int i = 0; i < NPORTS; i++) begin
      drop[i] = !reset && bus.in_valid[i] &&
                ((dir[i] == DIR_W'(i)) || (32'(dir[i]) >= 32'(NPORTS)));
    end
  end

  // Request matrix: routed here, not a U-turn, link free, and not shut out by a wormhole lock.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        req[o][i] = !reset && bus.in_valid[i] && (dir[i] == DIR_W'(o)) && (o != i) &&
                    !bus.out_busy[o] && (!lock_v[o] || (lock_src[o] == PW'(i)));
      end
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    rr_arbiter_n #(
      .N (NPORTS)
    ) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req[o]),
      .hold  (lock_v[o]),
      .gnt   (gnt[o])
    );
  end

  // Crossbar: AND-OR the one-hot grant over the input items, and encode the winner index.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      xbar[o]    = '0;
      gnt_idx[o] = '0;
      gnt_any[o] = |gnt[o];
      for (int i = 0; i < NPORTS; i++) begin
        xbar[o] = xbar[o] | (item[i] & {ITEM_W{gnt[o][i]}});
        if (gnt[o][i]) begin
          gnt_idx[o] = PW'(i);
        end
      end
    end
  end

  // Each input routes to a single output, so at most one grant plus the drop strobe per input.
  always_comb begin
    rd = drop;
    for (int o = 0; o < NPORTS; o++) begin
      rd = rd | gnt[o];
    end
  end
  assign bus.in_read = rd;

  // Output registers: strobe every granted item one cycle later; data holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ena_q <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        out_q[o] <= '0;
      end
    end else begin
      ena_q <= gnt_any;
      for (int o = 0; o < NPORTS; o++) begin
        if (gnt_any[o]) begin
          out_q[o] <= xbar[o];
        end
      end
    end
  end

  // Wormhole lock: a granted non-tail item pins the output to its input until the tail passes.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_v <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        lock_src[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if ((LOCK_EN != 0) && gnt_any[o]) begin
          lock_v[o]   <= !xbar[o][TAIL_BIT];
          lock_src[o] <= gnt_idx[o];
        end
      end
    end
  end

  // Add every drop of this cycle, then clamp to all-ones.
  always_comb begin
    drop_sum = CW'(drop_cnt) + CW'(popcount32(32'(drop)));
  end

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop_sum > CW'({DROP_W{1'b1}})) begin
      drop_cnt <= '1;
    end else begin
      drop_cnt <= drop_sum[DROP_W-1:0];
    end
  end

endmodule
